// File: rtl/ika87ad_mc_sequencer_pkg.sv
// rtl/ika87ad_mc_sequencer_pkg.sv - microword fields, bus codes, fixed addresses and states for the microcode sequencer
package IKA87AD_mnemonics;

    // Microword field positions
    localparam int MW_TYPE_HI = 17;
    localparam int MW_TYPE_LO = 16;
    localparam int MW_FLAG    = 15;
    localparam int MW_SKIP    = 14;
    localparam int MW_BUS_HI  = 1;
    localparam int MW_BUS_LO  = 0;

    // Bus cycle codes carried in microword bits [1:0]
    localparam logic [1:0] BUS_IDLE = 2'b00;
    localparam logic [1:0] BUS_RD3  = 2'b01;
    localparam logic [1:0] BUS_WR3  = 2'b10;
    localparam logic [1:0] BUS_RD4  = 2'b11;

    // Fixed microcode addresses: instruction-decode parking slot and interrupt routine
    localparam logic [7:0] IRD       = 8'hFE;
    localparam logic [7:0] INT_ENTRY = 8'hF0;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_DECODE = 3'd1,
        ST_FETCHW = 3'd2,
        ST_EXEC   = 3'd3,
        ST_BWAIT  = 3'd4
    } seq_state_e;

    // Step index saturates; running past 15 is a microcode bug, not something to recover from
    function automatic logic [3:0] step_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

endpackage

// File: rtl/ika87ad_mc_sequencer.sv
// rtl/ika87ad_mc_sequencer.sv - microcode sequencer; interrupt entry enabled by IKA87AD_MCSEQ_INT_EN
module ika87ad_mc_sequencer (
    input  logic        i_CLK,
    input  logic        i_RST_n,
    input  logic        i_CEN,
    input  logic [7:0]  i_DECODE_ADDR,
    input  logic        i_OPCODE_VALID,
    input  logic [17:0] i_MCROM_DATA,
    input  logic        i_BUS_DONE,
    input  logic        i_SKIP_COND,
    input  logic        i_INT_REQ,
    output logic        o_MCROM_READ_TICK,
    output logic [7:0]  o_MCROM_ADDR,
    output logic        o_MC_VALID,
    output logic        o_SQUASH,
    output logic        o_FLAG_EN,
    output logic        o_BUS_START,
    output logic [1:0]  o_BUS_CYCLE,
    output logic [3:0]  o_STEP,
    output logic        o_INT_ACK
);
    import IKA87AD_mnemonics::*;

    seq_state_e state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic       tick_q, tick_d;
    logic [3:0] step_q, step_d;
    logic       squash_q, squash_d;
    logic       skip_q, skip_d;
    logic       start_q, start_d;
    logic [1:0] bus_cycle_q, bus_cycle_d;
    logic       int_ack_q, int_ack_d;

    logic [1:0] mw_bus;
    logic       exec;
    logic       int_take;
    logic       unused_ok;

    assign mw_bus = i_MCROM_DATA[MW_BUS_HI:MW_BUS_LO];
    assign exec   = (state_q == ST_EXEC);

`ifdef IKA87AD_MCSEQ_INT_EN
    // A skipped instruction must run to completion, so the interrupt waits for the next decode
    assign int_take = i_INT_REQ & ~skip_q;
`else
    assign int_take = 1'b0;
`endif

    // Type field is consumed elsewhere; spare bits carry no meaning for sequencing
    assign unused_ok = ^{i_INT_REQ, i_MCROM_DATA[MW_TYPE_HI:MW_TYPE_LO], i_MCROM_DATA[13:2]};

    // State register; reset parks on the decode slot with an RD4 pending
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q     <= ST_BOOT;
            addr_q      <= IRD;
            tick_q      <= 1'b0;
            step_q      <= 4'd0;
            squash_q    <= 1'b0;
            skip_q      <= 1'b0;
            start_q     <= 1'b0;
            bus_cycle_q <= BUS_RD4;
            int_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            tick_q      <= tick_d;
            step_q      <= step_d;
            squash_q    <= squash_d;
            skip_q      <= skip_d;
            start_q     <= start_d;
            bus_cycle_q <= bus_cycle_d;
            int_ack_q   <= int_ack_d;
        end
    end

    // Next state: everything holds while i_CEN is low, pulses clear on the following i_CEN
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tick_d      = tick_q;
        step_d      = step_q;
        squash_d    = squash_q;
        skip_d      = skip_q;
        start_d     = start_q;
        bus_cycle_d = bus_cycle_q;
        int_ack_d   = int_ack_q;
        if (i_CEN) begin
            tick_d    = 1'b0;
            start_d   = 1'b0;
            int_ack_d = 1'b0;
            unique case (state_q)
                ST_BOOT: begin
                    start_d     = 1'b1;
                    bus_cycle_d = BUS_RD4;
                    state_d     = ST_BWAIT;
                end
                ST_DECODE: begin
                    if (i_OPCODE_VALID) begin
                        addr_d    = int_take ? INT_ENTRY : i_DECODE_ADDR;
                        int_ack_d = int_take;
                        tick_d    = 1'b1;
                        step_d    = 4'd0;
                        squash_d  = skip_q;
                        skip_d    = 1'b0;
                        state_d   = ST_FETCHW;
                    end
                end
                ST_FETCHW: begin
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    bus_cycle_d = mw_bus;
                    if (i_MCROM_DATA[MW_SKIP] && i_SKIP_COND && !squash_q) begin
                        skip_d = 1'b1;
                    end
                    if (mw_bus == BUS_IDLE) begin
                        addr_d  = addr_q + 8'd1;
                        tick_d  = 1'b1;
                        step_d  = step_inc(step_q);
                        state_d = ST_FETCHW;
                    end else begin
                        state_d = ST_BWAIT;
                    end
                end
                ST_BWAIT: begin
                    if (i_BUS_DONE) begin
                        if (bus_cycle_q == BUS_RD4) begin
                            addr_d  = IRD;
                            state_d = ST_DECODE;
                        end else begin
                            addr_d  = addr_q + 8'd1;
                            tick_d  = 1'b1;
                            step_d  = step_inc(step_q);
                            state_d = ST_FETCHW;
                        end
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    assign o_MCROM_READ_TICK = tick_q;
    assign o_MCROM_ADDR      = addr_q;
    assign o_MC_VALID        = exec;
    assign o_SQUASH          = squash_q;
    assign o_FLAG_EN         = exec & i_MCROM_DATA[MW_FLAG] & ~squash_q;
    assign o_BUS_START       = start_q | (exec & (mw_bus != BUS_IDLE));
    assign o_BUS_CYCLE       = exec ? mw_bus : bus_cycle_q;
    assign o_STEP            = step_q;
    assign o_INT_ACK         = int_ack_q;

endmodule

// File: tb/tb_ika87ad_mc_sequencer.sv
// tb/tb_ika87ad_mc_sequencer.sv - directed and randomized bench for ika87ad_mc_sequencer
module tb_ika87ad_mc_sequencer;
    localparam int NPROG = 60;
    localparam int NRTN  = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic [7:0]  dec_addr = 8'd0;
    logic        op_valid = 1'b0;
    logic [17:0] rom_q = 18'd0;
    logic        bus_done = 1'b0;
    logic        skip_cond = 1'b0;
    logic        int_req = 1'b0;
    logic        o_tick, o_valid, o_squash, o_flag, o_start, o_ack;
    logic [7:0]  o_addr;
    logic [1:0]  o_cyc;
    logic [3:0]  o_step;

    logic [17:0] rom [256];
    logic [17:0] rtn_word [NRTN][20];
    int          rtn_len [NRTN];
    logic [7:0]  rtn_base [NRTN];
    int          prog [NPROG];

    int total = 0;
    int bad = 0;
    bit model_on = 1'b0;
    int m_idx = 0, m_k = 0;
    bit m_squash = 1'b0, m_skip = 1'b0;

    always #5 clk = ~clk;

    ika87ad_mc_sequencer dut (
        .i_CLK(clk), .i_RST_n(rst_n), .i_CEN(cen),
        .i_DECODE_ADDR(dec_addr), .i_OPCODE_VALID(op_valid),
        .i_MCROM_DATA(rom_q), .i_BUS_DONE(bus_done),
        .i_SKIP_COND(skip_cond), .i_INT_REQ(int_req),
        .o_MCROM_READ_TICK(o_tick), .o_MCROM_ADDR(o_addr),
        .o_MC_VALID(o_valid), .o_SQUASH(o_squash), .o_FLAG_EN(o_flag),
        .o_BUS_START(o_start), .o_BUS_CYCLE(o_cyc), .o_STEP(o_step),
        .o_INT_ACK(o_ack)
    );

    // Synchronous microcode ROM
    always @(posedge clk) begin
        if (cen && o_tick) rom_q <= rom[o_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic dcyc(input bit done, input bit valid, input logic [7:0] a, input bit skip, input bit intr);
        bus_done = done; op_valid = valid; dec_addr = a; skip_cond = skip; int_req = intr; cen = 1'b1;
        @(posedge clk); #1;
        bus_done = 1'b0; op_valid = 1'b0; skip_cond = 1'b0; int_req = 1'b0;
    endtask

    task automatic idle();
        dcyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic boot_seq();
        idle();
        chk("boot_start", o_start, 1); chk("boot_cycle", o_cyc, 3); chk("boot_valid", o_valid, 0);
        idle();
        chk("boot_start_pulse", o_start, 0);
        idle();
        dcyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("boot_addr_ird", o_addr, 8'hFE); chk("boot_step", o_step, 0); chk("boot_tick", o_tick, 0);
    endtask

    task automatic run_mvi(input bit sq, input bit flag, input bit intr);
        dcyc(1'b0, 1'b1, 8'h40, 1'b0, intr);
        chk("mvi_tick", o_tick, 1); chk("mvi_addr0", o_addr, 8'h40); chk("mvi_step0", o_step, 0);
        chk("mvi_squash", o_squash, sq); chk("mvi_noack", o_ack, 0);
        idle();
        chk("mvi_valid", o_valid, 1); chk("mvi_start_rd3", o_start, 1); chk("mvi_cyc_rd3", o_cyc, 1);
        chk("mvi_flag", o_flag, flag);
        idle();
        chk("mvi_wait_start", o_start, 0); chk("mvi_wait_valid", o_valid, 0);
        dcyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("mvi_addr1", o_addr, 8'h41); chk("mvi_step1", o_step, 1); chk("mvi_tick1", o_tick, 1);
        idle();
        chk("mvi_start_rd4", o_start, 1); chk("mvi_cyc_rd4", o_cyc, 3); chk("mvi_flag1", o_flag, 0);
        idle();
        dcyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("mvi_end_ird", o_addr, 8'hFE);
    endtask

    task automatic run_skip();
        dcyc(1'b0, 1'b1, 8'h60, 1'b0, 1'b0);
        idle();
        chk("skip_exec", o_valid, 1);
        dcyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        idle();
        dcyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("skip_end_ird", o_addr, 8'hFE);
    endtask

    // Model: instruction-level walk through the issued program, checked at every executed microstep
    initial begin
        logic [17:0] w;
        int r;
        forever begin
            @(negedge clk); #2;
            if (model_on && cen && o_valid) begin
                if (m_idx >= NPROG) begin
                    chk("extra_exec", 1, 0);
                end else begin
                    r = prog[m_idx];
                    w = rtn_word[r][m_k];
                    chk("m_addr", o_addr, rtn_base[r] + 8'(m_k));
                    chk("m_step", o_step, (m_k > 15) ? 15 : m_k);
                    chk("m_squash", o_squash, m_squash);
                    chk("m_flag", o_flag, w[15] & ~m_squash);
                    chk("m_start", o_start, w[1:0] != 2'b00);
                    chk("m_cycle", o_cyc, w[1:0]);
                    if (w[14] && skip_cond && !m_squash) m_skip = 1'b1;
                    m_k++;
                    if (m_k == rtn_len[r]) begin
                        m_idx++; m_k = 0; m_squash = m_skip; m_skip = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int cyc, d_idx, bwait;
        bit busy, dec_pending;
        logic [1:0] bcyc;
        for (int i = 0; i < 256; i++) rom[i] = 18'd0;
        rom[8'h40] = 18'h08001; rom[8'h41] = 18'h00003;
        rom[8'h50] = 18'h00000; rom[8'h51] = 18'h00003;
        rom[8'h60] = 18'h04000; rom[8'h61] = 18'h00003;
        rom[8'h70] = 18'h04002; rom[8'h71] = 18'h00003;
        rom[8'hF0] = 18'h00003;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", o_addr, 8'hFE); chk("rst_cycle", o_cyc, 3); chk("rst_start", o_start, 0);
        chk("rst_valid", o_valid, 0); chk("rst_step", o_step, 0); chk("rst_tick", o_tick, 0);
        chk("rst_squash", o_squash, 0); chk("rst_ack", o_ack, 0);
        rst_n = 1'b1;
        boot_seq();
        run_mvi(1'b0, 1'b1, 1'b0);

        // IDLE microstep: two i_CEN, with a freeze in the middle
        dcyc(1'b0, 1'b1, 8'h50, 1'b0, 1'b0);
        idle();
        chk("mul_valid", o_valid, 1); chk("mul_step0", o_step, 0); chk("mul_nostart", o_start, 0);
        chk("mul_cyc_idle", o_cyc, 0);
        cen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("freeze_valid", o_valid, 1); chk("freeze_addr", o_addr, 8'h50);
        idle();
        chk("mul_fetchw", o_valid, 0); chk("mul_step1", o_step, 1); chk("mul_addr1", o_addr, 8'h51);
        idle();
        chk("mul_exec2", o_valid, 1); chk("mul_rd4", o_cyc, 3); chk("mul_rd4_start", o_start, 1);
        idle();
        dcyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        run_skip();
        run_mvi(1'b1, 1'b0, 1'b0);
        run_mvi(1'b0, 1'b1, 1'b0);

`ifdef IKA87AD_MCSEQ_INT_EN
        dcyc(1'b0, 1'b1, 8'h40, 1'b0, 1'b1);
        chk("int_addr", o_addr, 8'hF0); chk("int_ack", o_ack, 1);
        idle();
        chk("int_ack_pulse", o_ack, 0); chk("int_rd4", o_cyc, 3);
        idle();
        dcyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        run_skip();
        run_mvi(1'b1, 1'b0, 1'b1);
`else
        run_mvi(1'b0, 1'b1, 1'b1);
`endif

        // Reset while a WR3 is outstanding, with the skip latch armed
        dcyc(1'b0, 1'b1, 8'h70, 1'b0, 1'b0);
        idle();
        chk("wr3_cycle", o_cyc, 2); chk("wr3_start", o_start, 1);
        dcyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("wr3_bwait_cycle", o_cyc, 2);
        #2; rst_n = 1'b0; #1;
        chk("arst_addr", o_addr, 8'hFE); chk("arst_cycle", o_cyc, 3); chk("arst_start", o_start, 0);
        chk("arst_squash", o_squash, 0); chk("arst_step", o_step, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        boot_seq();
        run_mvi(1'b0, 1'b1, 1'b0);

        // Randomized program
        for (int r = 0; r < NRTN; r++) begin
            rtn_base[r] = (r == NRTN - 1) ? 8'h00 : 8'(8'h80 + r * 16);
            rtn_len[r]  = (r == NRTN - 1) ? 20 : int'($urandom_range(1, 8));
            for (int k = 0; k < rtn_len[r]; k++) begin
                rtn_word[r][k] = 18'($urandom);
                rtn_word[r][k][1:0] = (k == rtn_len[r] - 1) ? 2'b11 : 2'($urandom_range(0, 2));
                rom[rtn_base[r] + 8'(k)] = rtn_word[r][k];
            end
        end
        for (int i = 0; i < NPROG; i++) prog[i] = (i == 0) ? NRTN - 1 : int'($urandom_range(0, NRTN - 1));

        rst_n = 1'b0; cen = 1'b0;
        @(posedge clk); #1;
        m_idx = 0; m_k = 0; m_squash = 1'b0; m_skip = 1'b0;
        busy = 1'b0; dec_pending = 1'b0; d_idx = 0; bwait = 0; bcyc = 2'b00; cyc = 0;
        rst_n = 1'b1;
        model_on = 1'b1;
        while (m_idx < NPROG && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            cen = ($urandom_range(0, 3) != 0);
            skip_cond = 1'($urandom_range(0, 1));
`ifdef IKA87AD_MCSEQ_INT_EN
            int_req = 1'b0;
`else
            int_req = 1'($urandom_range(0, 1));
`endif
            if (op_valid && o_tick) begin
                op_valid = 1'b0; d_idx++;
            end
            if (!op_valid) dec_addr = 8'($urandom);
            if (!op_valid && dec_pending && d_idx < NPROG && $urandom_range(0, 1) == 1) begin
                op_valid = 1'b1; dec_addr = rtn_base[prog[d_idx]]; dec_pending = 1'b0;
            end
            if (busy) bus_done = (bwait == 0);
            else      bus_done = !o_start && ($urandom_range(0, 3) == 0);
            if (cen) begin
                if (busy) begin
                    if (bwait == 0) begin
                        busy = 1'b0;
                        if (bcyc == 2'b11) dec_pending = 1'b1;
                    end else begin
                        bwait--;
                    end
                end
                if (o_start) begin
                    busy = 1'b1; bcyc = o_cyc; bwait = int'($urandom_range(0, 3));
                end
            end
        end
        @(negedge clk); #3;
        model_on = 1'b0;
        chk("all_instr_executed", m_idx, NPROG);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
